// File: rtl/hs_npu_mem_adapter_if.sv
// NPU-side burst handshake and single-word system bus signals of the memory adapter.
// The master modport is the adapter's view; the slave modport is the NPU/bus environment.
interface hs_npu_mem_adapter_if #(
    parameter int BURST_SIZE = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                                 npu_read_ready;
    logic                                 npu_write_valid;
    logic                                 npu_invalidate;
    logic [ADDR_WIDTH-1:0]                npu_addr;
    logic [BURST_SIZE-1:0][DATA_WIDTH-1:0] npu_wdata;
    logic [BURST_SIZE-1:0][DATA_WIDTH-1:0] npu_rdata;
    logic                                 npu_rvalid;
    logic                                 npu_wready;
    logic                                 bus_req;
    logic                                 bus_we;
    logic [ADDR_WIDTH-1:0]                bus_addr;
    logic [DATA_WIDTH-1:0]                bus_wdata;
    logic                                 bus_gnt;
    logic                                 bus_rvalid;
    logic [DATA_WIDTH-1:0]                bus_rdata;

    modport master (
        input  npu_read_ready, npu_write_valid, npu_invalidate, npu_addr, npu_wdata,
        output npu_rdata, npu_rvalid, npu_wready,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        output npu_read_ready, npu_write_valid, npu_invalidate, npu_addr, npu_wdata,
        input  npu_rdata, npu_rvalid, npu_wready,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/hs_npu_mem_adapter.sv
// NPU burst to single-word req/gnt/rvalid bus adapter.
// Reads are split into BURST_SIZE word reads and regathered; writes are serialised;
// an invalidate aborts the burst and drains read responses that are still in flight.
module hs_npu_mem_adapter #(
    parameter int BURST_SIZE = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    hs_npu_mem_adapter_if.master io
);
    localparam int CW = $clog2(BURST_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(BURST_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DONE,
        WR_ISSUE,
        WR_DONE,
        DRAIN
    } state_t;

    state_t                                state;
    logic [ADDR_WIDTH-1:0]                 base;
    logic [BURST_SIZE-1:0][DATA_WIDTH-1:0] wbuf;
    logic [BURST_SIZE-1:0][DATA_WIDTH-1:0] rbuf;
    logic [CW-1:0]                         issued;
    logic [CW-1:0]                         rsp_cnt;

    logic                  issuing;
    logic                  can_issue;
    logic                  fire;
    logic                  rsp_take;
    logic [CW-1:0]         issued_nxt;
    logic [CW-1:0]         rsp_nxt;
    logic [CW-1:0]         outst_nxt;
    logic [DATA_WIDTH-1:0] wsel;

    // Issue/response bookkeeping and the write word currently on offer.
    always_comb begin
        issuing    = (state == RD_ISSUE) || (state == WR_ISSUE);
        can_issue  = issuing && (issued < LAST);
        fire       = can_issue && io.bus_gnt;
        rsp_take   = io.bus_rvalid && ((state == RD_ISSUE) || (state == DRAIN)) &&
                     (rsp_cnt < issued);
        issued_nxt = issued + CW'(fire);
        rsp_nxt    = rsp_cnt + CW'(rsp_take);
        // A grant landing in the invalidate cycle is already counted here.
        outst_nxt  = issued_nxt - rsp_nxt;
        wsel       = '0;
        for (int unsigned i = 0; i < BURST_SIZE; i++) begin
            if (issued == CW'(i)) begin
                wsel = wbuf[i];
            end
        end
    end

    assign io.bus_req    = can_issue;
    assign io.bus_we     = (state == WR_ISSUE);
    assign io.bus_addr   = base + (ADDR_WIDTH'(issued) << 2);
    assign io.bus_wdata  = wsel;
    assign io.npu_rdata  = rbuf;
    // Completion pulses are state-decoded so an invalidate in the DONE cycle can mask them.
    assign io.npu_rvalid = (state == RD_DONE) && !io.npu_invalidate;
    assign io.npu_wready = (state == WR_DONE) && !io.npu_invalidate;

    // Burst FSM with its address, data and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            base    <= '0;
            wbuf    <= '0;
            rbuf    <= '0;
            issued  <= '0;
            rsp_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.npu_read_ready && !io.npu_invalidate) begin
                        base    <= io.npu_addr;
                        issued  <= '0;
                        rsp_cnt <= '0;
                        state   <= RD_ISSUE;
                    end else if (io.npu_write_valid && !io.npu_invalidate) begin
                        base    <= io.npu_addr;
                        wbuf    <= io.npu_wdata;
                        issued  <= '0;
                        rsp_cnt <= '0;
                        state   <= WR_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    issued  <= issued_nxt;
                    rsp_cnt <= rsp_nxt;
                    if (rsp_take && !io.npu_invalidate) begin
                        for (int unsigned i = 0; i < BURST_SIZE; i++) begin
                            if (rsp_cnt == CW'(i)) begin
                                rbuf[i] <= io.bus_rdata;
                            end
                        end
                    end
                    if (io.npu_invalidate) begin
                        state <= (outst_nxt != '0) ? DRAIN : IDLE;
                    end else if (rsp_nxt == LAST) begin
                        state <= RD_DONE;
                    end
                end
                WR_ISSUE: begin
                    issued <= issued_nxt;
                    if (io.npu_invalidate) begin
                        state <= IDLE;
                    end else if (issued_nxt == LAST) begin
                        state <= WR_DONE;
                    end
                end
                RD_DONE, WR_DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    rsp_cnt <= rsp_nxt;
                    if (outst_nxt == '0) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hs_npu_mem_adapter.sv
// Directed bench for hs_npu_mem_adapter: a bus responder process with configurable
// grant behaviour and response latency, plus a main sequence of hand-checked bursts.
module tb_hs_npu_mem_adapter;
    localparam int BS = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic clk;
    logic rst_n;

    hs_npu_mem_adapter_if #(.BURST_SIZE(BS), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    hs_npu_mem_adapter #(.BURST_SIZE(BS), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];
    rsp_t        rq[$];
    logic [31:0] xa[$];
    logic [31:0] xd[$];
    logic        xw[$];

    int cyc = 0;
    int rsp_lat = 1;
    int gnt_mode = 0;            // 0: always grant, 1: random grant
    logic [31:0] stall_addr = '0;
    int stall_left = 0;
    int stall_seen = 0;
    int last_gnt_cyc = 0;
    int n_rv = 0;
    int rv_cyc = 0;
    logic [BS-1:0][31:0] rv_data = '0;
    int n_wr = 0;
    int wr_cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hBAD0_0000;
    endfunction

    // Bus responder and NPU-side monitor, all on the falling edge.
    initial begin
        bus.bus_gnt    = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus.bus_rvalid = 1'b1;
                bus.bus_rdata  = rq[0].data;
                void'(rq.pop_front());
            end else begin
                bus.bus_rvalid = 1'b0;
                bus.bus_rdata  = '0;
            end
            if (stall_left > 0 && bus.bus_req && bus.bus_addr == stall_addr) begin
                bus.bus_gnt = 1'b0;
                stall_left--;
                stall_seen++;
            end else if (gnt_mode == 1) begin
                bus.bus_gnt = 1'($urandom_range(0, 1));
            end else begin
                bus.bus_gnt = 1'b1;
            end
            if (bus.bus_req && bus.bus_gnt) begin
                xa.push_back(bus.bus_addr);
                xd.push_back(bus.bus_wdata);
                xw.push_back(bus.bus_we);
                last_gnt_cyc = cyc;
                if (!bus.bus_we) begin
                    rq.push_back('{data: mem_rd(bus.bus_addr), due: cyc + rsp_lat});
                end
            end
            if (bus.npu_rvalid) begin
                n_rv++;
                rv_cyc  = cyc;
                rv_data = bus.npu_rdata;
            end
            if (bus.npu_wready) begin
                n_wr++;
                wr_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_read(input logic [31:0] a, output int t0);
        bus.npu_addr       = a;
        bus.npu_read_ready = 1'b1;
        t0 = cyc + 1;
        tick();
        bus.npu_read_ready = 1'b0;
    endtask

    // Keeps npu_write_valid up until the wready pulse so exactly one write is taken.
    task automatic hold_write_until_done();
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.npu_wready) begin
                seen = 1;
                break;
            end
        end
        bus.npu_write_valid = 1'b0;
        check_val("wr_done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        int t0;
        int b;
        int rv0;
        int wr0;

        rst_n               = 1'b0;
        bus.npu_read_ready  = 1'b0;
        bus.npu_write_valid = 1'b0;
        bus.npu_invalidate  = 1'b0;
        bus.npu_addr        = '0;
        bus.npu_wdata       = '0;
        mem[32'h100] = 32'hAABBCCDD;  mem[32'h104] = 32'h11223344;
        mem[32'h110] = 32'h01020304;  mem[32'h114] = 32'h05060708;
        mem[32'h280] = 32'h28000000;  mem[32'h284] = 32'h28400000;
        mem[32'h300] = 32'h30003000;  mem[32'h304] = 32'h30403040;
        mem[32'h400] = 32'h40004000;  mem[32'h404] = 32'h40404040;
        mem[32'h500] = 32'h50005000;  mem[32'h504] = 32'h50405040;

        wait_cycles(3);
        check_val("rst_bus_req", 64'(bus.bus_req), 64'd0);
        check_val("rst_bus_addr", 64'(bus.bus_addr), 64'd0);
        check_val("rst_bus_we_wdata", {31'd0, bus.bus_we, bus.bus_wdata}, 64'd0);
        check_val("rst_npu_pulses", {bus.npu_rvalid, bus.npu_wready}, 64'd0);
        check_val("rst_npu_rdata", 64'(bus.npu_rdata), 64'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: plain read at 0x100
        b = xa.size(); rv0 = n_rv;
        start_read(32'h100, t0);
        wait_cycles(10);
        check_val("t1_xfers", 64'(xa.size() - b), 64'd2);
        check_val("t1_addr0", 64'(xa[b]), 64'h100);
        check_val("t1_addr1", 64'(xa[b+1]), 64'h104);
        check_val("t1_we", {xw[b], xw[b+1]}, 64'd0);
        check_val("t1_pulses", 64'(n_rv - rv0), 64'd1);
        check_val("t1_latency", 64'(rv_cyc - t0), 64'd4);
        check_val("t1_rdata0", 64'(rv_data[0]), 64'hAABBCCDD);
        check_val("t1_rdata1", 64'(rv_data[1]), 64'h11223344);

        // 2: 3-cycle grant stall on the second word
        b = xa.size(); rv0 = n_rv;
        stall_addr = 32'h114; stall_left = 3; stall_seen = 0;
        start_read(32'h110, t0);
        wait_cycles(14);
        check_val("t2_stall_held", 64'(stall_seen), 64'd3);
        check_val("t2_addr1", 64'(xa[b+1]), 64'h114);
        check_val("t2_pulses", 64'(n_rv - rv0), 64'd1);
        check_val("t2_latency", 64'(rv_cyc - t0), 64'd7);
        check_val("t2_rdata", 64'(rv_data), {32'h05060708, 32'h01020304});

        // 3: write with random grants
        b = xa.size(); wr0 = n_wr;
        gnt_mode = 1;
        bus.npu_addr        = 32'h200;
        bus.npu_wdata[0]    = 32'hDEADBEEF;
        bus.npu_wdata[1]    = 32'hCAFEF00D;
        bus.npu_write_valid = 1'b1;
        hold_write_until_done();
        gnt_mode = 0;
        wait_cycles(3);
        check_val("t3_xfers", 64'(xa.size() - b), 64'd2);
        check_val("t3_we", {xw[b], xw[b+1]}, 64'd3);
        check_val("t3_w0", {xa[b], xd[b]}, {32'h200, 32'hDEADBEEF});
        check_val("t3_w1", {xa[b+1], xd[b+1]}, {32'h204, 32'hCAFEF00D});
        check_val("t3_pulses", 64'(n_wr - wr0), 64'd1);
        check_val("t3_after_last_gnt", 64'(wr_cyc - last_gnt_cyc), 64'd1);

        // 4: invalidate after the first read grant, then a clean read at 0x300
        b = xa.size(); rv0 = n_rv;
        start_read(32'h280, t0);
        tick();
        bus.npu_invalidate = 1'b1;
        tick();
        bus.npu_invalidate = 1'b0;
        check_val("t4_req_dropped", 64'(bus.bus_req), 64'd0);
        wait_cycles(8);
        check_val("t4_xfers", 64'(xa.size() - b), 64'd2);
        check_val("t4_no_pulse", 64'(n_rv - rv0), 64'd0);
        start_read(32'h300, t0);
        wait_cycles(10);
        check_val("t4_next_pulses", 64'(n_rv - rv0), 64'd1);
        check_val("t4_next_rdata", 64'(rv_data), {32'h30403040, 32'h30003000});

        // 5: read and write requested together: read first
        b = xa.size(); rv0 = n_rv; wr0 = n_wr;
        bus.npu_addr        = 32'h400;
        bus.npu_wdata[0]    = 32'h0000AAAA;
        bus.npu_wdata[1]    = 32'h0000BBBB;
        bus.npu_read_ready  = 1'b1;
        bus.npu_write_valid = 1'b1;
        tick();
        bus.npu_read_ready  = 1'b0;
        hold_write_until_done();
        wait_cycles(3);
        check_val("t5_xfers", 64'(xa.size() - b), 64'd4);
        check_val("t5_order_we", {xw[b], xw[b+1], xw[b+2], xw[b+3]}, 64'b0011);
        check_val("t5_rd_addrs", {xa[b], xa[b+1]}, {32'h400, 32'h404});
        check_val("t5_wr_words", {xd[b+2], xd[b+3]}, {32'h0000AAAA, 32'h0000BBBB});
        check_val("t5_rdata", 64'(rv_data), {32'h40404040, 32'h40004000});
        check_val("t5_pulses", {32'(n_rv - rv0), 32'(n_wr - wr0)}, {32'd1, 32'd1});
        check_val("t5_rd_before_wr", 64'(wr_cyc > rv_cyc), 64'd1);

        // 6: reset with two reads outstanding; late responses must be ignored
        rv0 = n_rv;
        rsp_lat = 4;
        start_read(32'h500, t0);
        tick();
        tick();
        check_val("t6_outstanding", 64'(rq.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_req_we", {bus.bus_req, bus.bus_we}, 64'd0);
        check_val("t6_rst_addr", 64'(bus.bus_addr), 64'd0);
        check_val("t6_rst_rdata", 64'(bus.npu_rdata), 64'd0);
        tick();
        rst_n = 1'b1;
        wait_cycles(10);
        check_val("t6_no_pulse", 64'(n_rv - rv0), 64'd0);
        check_val("t6_rdata_still_0", 64'(bus.npu_rdata), 64'd0);
        rsp_lat = 1;
        start_read(32'h300, t0);
        wait_cycles(10);
        check_val("t6_recover_rdata", 64'(rv_data), {32'h30403040, 32'h30003000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
